// File: rtl/sync_multichannel_fifo.sv
// Single-clock multi-channel FIFO: NUM_CH circular buffers of DEPTH words carved
// out of one shared memory, one write port and one read port per cycle.

module sync_multichannel_fifo_ch #(
  parameter int PTR_WIDTH     = 4,
  parameter int AFULL_THRESH  = 12,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic                 pop,
  output logic [PTR_WIDTH-1:0] waddr,
  output logic [PTR_WIDTH-1:0] raddr,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic [PTR_WIDTH:0]   count
);
  localparam logic [PTR_WIDTH:0] ONE = 1;
  localparam logic [PTR_WIDTH:0] AF  = AFULL_THRESH[PTR_WIDTH:0];
  localparam logic [PTR_WIDTH:0] AE  = AEMPTY_THRESH[PTR_WIDTH:0];

  // Extra MSB distinguishes full from empty when the low bits match.
  logic [PTR_WIDTH:0] wptr, rptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + ONE;
      if (pop)  rptr <= rptr + ONE;
    end
  end

  assign waddr        = wptr[PTR_WIDTH-1:0];
  assign raddr        = rptr[PTR_WIDTH-1:0];
  assign count        = wptr - rptr;
  assign empty        = (wptr == rptr);
  assign full         = (wptr[PTR_WIDTH] != rptr[PTR_WIDTH]) &&
                        (wptr[PTR_WIDTH-1:0] == rptr[PTR_WIDTH-1:0]);
  assign almost_full  = (count >= AF);
  assign almost_empty = (count <= AE);
endmodule

module sync_multichannel_fifo #(
  parameter int DATA_WIDTH    = 8,
  parameter int DEPTH         = 16,
  parameter int PTR_WIDTH     = 4,
  parameter int NUM_CH        = 4,
  parameter int CH_WIDTH      = 2,
  parameter int AFULL_THRESH  = 12,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            wen,
  input  logic [CH_WIDTH-1:0]             wch,
  input  logic [DATA_WIDTH-1:0]           data_in,
  input  logic                            ren,
  input  logic [CH_WIDTH-1:0]             rch,
  output logic [DATA_WIDTH-1:0]           data_out,
  output logic                            rvalid,
  output logic [NUM_CH-1:0]               full,
  output logic [NUM_CH-1:0]               empty,
  output logic [NUM_CH-1:0]               almost_full,
  output logic [NUM_CH-1:0]               almost_empty,
  output logic [NUM_CH*(PTR_WIDTH+1)-1:0] count,
  output logic                            wr_err,
  output logic                            rd_err
);
  typedef struct packed {
    logic                en;
    logic [CH_WIDTH-1:0] ch;
  } port_req_t;

  port_req_t wreq, rreq;
  logic      wr_acc, rd_acc;

  logic [DATA_WIDTH-1:0]                 mem [NUM_CH*DEPTH];
  logic [NUM_CH-1:0][PTR_WIDTH-1:0]      wlo, rlo;
  logic [NUM_CH-1:0][PTR_WIDTH:0]        cnt;

  assign wreq   = '{en: wen, ch: wch};
  assign rreq   = '{en: ren, ch: rch};
  // Acceptance uses pre-edge flags, so a same-cycle write never feeds a read.
  assign wr_acc = wreq.en && !full[wreq.ch];
  assign rd_acc = rreq.en && !empty[rreq.ch];

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    sync_multichannel_fifo_ch #(
      .PTR_WIDTH    (PTR_WIDTH),
      .AFULL_THRESH (AFULL_THRESH),
      .AEMPTY_THRESH(AEMPTY_THRESH)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .push        (wr_acc && (wreq.ch == CH_WIDTH'(c))),
      .pop         (rd_acc && (rreq.ch == CH_WIDTH'(c))),
      .waddr       (wlo[c]),
      .raddr       (rlo[c]),
      .full        (full[c]),
      .empty       (empty[c]),
      .almost_full (almost_full[c]),
      .almost_empty(almost_empty[c]),
      .count       (cnt[c])
    );
  end

  assign count = cnt;

  always_ff @(posedge clk) begin
    if (wr_acc) mem[{wreq.ch, wlo[wreq.ch]}] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_out <= '0;
      rvalid   <= 1'b0;
      wr_err   <= 1'b0;
      rd_err   <= 1'b0;
    end else begin
      if (rd_acc) data_out <= mem[{rreq.ch, rlo[rreq.ch]}];
      rvalid <= rd_acc;
      wr_err <= wreq.en && full[wreq.ch];
      rd_err <= rreq.en && empty[rreq.ch];
    end
  end
endmodule

// File: doc/sync_multichannel_fifo.md
Name: sync_multichannel_fifo

Overview:
Single-clock, multi-channel FIFO built on one shared memory array, partitioned into NUM_CH independent circular buffers of DEPTH entries each. One write port and one read port per cycle; each selects its channel with a channel index. Per-channel full/empty/almost flags and occupancy counts. Registered read data with a valid strobe. Intended as the buffering stage between a channel demux and a shared downstream consumer.

Parameters:
DATA_WIDTH, 8, width of each stored word
DEPTH, 16, entries per channel (power of two)
PTR_WIDTH, 4, log2(DEPTH); per-channel pointers are PTR_WIDTH+1 bits
NUM_CH, 4, number of channels (power of two)
CH_WIDTH, 2, log2(NUM_CH)
AFULL_THRESH, 12, almost_full[c] asserted when count[c] >= AFULL_THRESH
AEMPTY_THRESH, 2, almost_empty[c] asserted when count[c] <= AEMPTY_THRESH

Ports:
clk  input  1  single clock; all state updates on posedge
rst  input  1  synchronous reset, active-high
wen  input  1  write request
wch  input  CH_WIDTH  write channel select
data_in  input  DATA_WIDTH  write data
ren  input  1  read request
rch  input  CH_WIDTH  read channel select
data_out  output  DATA_WIDTH  registered read data
rvalid  output  1  data_out carries a newly read word this cycle
full  output  NUM_CH  per-channel full
empty  output  NUM_CH  per-channel empty
almost_full  output  NUM_CH  per-channel count >= AFULL_THRESH
almost_empty  output  NUM_CH  per-channel count <= AEMPTY_THRESH
count  output  NUM_CH*(PTR_WIDTH+1)  per-channel occupancy, channel c at bits [c*(PTR_WIDTH+1) +: PTR_WIDTH+1]
wr_err  output  1  one-cycle pulse: previous cycle's write was rejected (full)
rd_err  output  1  one-cycle pulse: previous cycle's read was rejected (empty)

Behaviour:
- Memory: NUM_CH*DEPTH words, address {ch, ptr[PTR_WIDTH-1:0]}. Memory contents not reset.
- Per channel c: binary wptr[c], rptr[c], PTR_WIDTH+1 bits, wrap naturally mod 2*DEPTH.
- count[c] = wptr[c] - rptr[c] (PTR_WIDTH+1 bit modular subtraction); range 0..DEPTH.
- empty[c] = (wptr[c] == rptr[c]); full[c] = (MSBs differ, low PTR_WIDTH bits equal). All flags/counts combinational from registered pointers, so they reflect an accepted operation from the cycle after its clock edge.
- Write accepted iff wen && !full[wch]: mem written, wptr[wch] increments at that edge.
- Read accepted iff ren && !empty[rch]: data_out <= mem[{rch, rptr[rch] low bits}], rptr[rch] increments, rvalid = 1 the next cycle. Read latency 1 cycle.
- No accepted read: rvalid = 0 next cycle; data_out holds its last value.
- Simultaneous write and read, different channels: fully independent, both proceed.
- Simultaneous write and read, same channel: acceptance decided on pre-edge flags. Empty channel: read rejected, write accepted (no write-through bypass). Full channel: write rejected, read accepted. Otherwise both proceed; count unchanged.
- wr_err = 1 for exactly the cycle after wen && full[wch]; rd_err = 1 for the cycle after ren && empty[rch]. Rejected operations change no state.
- Pointer wrap: after DEPTH pushes/pops, low bits return to 0, MSB toggles; full/empty stay correct across unlimited wraps.
- Reset (rst = 1 at posedge): all pointers 0; empty = all 1s; full = 0; almost_empty = all 1s; almost_full = 0; count = 0; data_out = 0; rvalid = 0; wr_err = rd_err = 0. Reset overrides any same-cycle wen/ren. Reset mid-operation discards all channel contents; a read issued in the cycle before reset still produces rvalid = 1 for one cycle only if no reset is applied on that cycle's edge; otherwise rvalid = 0.

Test Plan:
- Reset, then write 0x11,0x22,0x33 to ch 2, read ch 2 three times -> data_out 0x11,0x22,0x33 on successive cycles each with rvalid=1; empty[2]=1, count ch2=0 afterwards.
- Write 16 words to ch 1 -> full[1]=1, count ch1=16, almost_full[1]=1 from 12th word; 17th write -> wr_err pulse next cycle, count stays 16, other channels empty=1.
- Read empty ch 0 -> rd_err=1 one cycle later, rvalid=0, data_out unchanged.
- Ch 3 holding 1 word, write and read ch 3 same cycle for 40 cycles with incrementing data -> each read returns previous write, count stays 1, no errors across pointer wraps.
- Empty ch 0: same-cycle write 0xA5 and read ch 0 -> read rejected (rd_err), next cycle read returns 0xA5 with rvalid=1.
- Fill ch 0 with 5 words, assert rst for one cycle -> all empty=1, counts 0, rvalid=0; subsequent read ch 0 -> rd_err.
